// File: rtl/kg_io_pkg.sv
// kg_io_pkg: shared types and constants for the keygen word-stream endpoint.
// Section ids, FSM states, default word counts and the two unload order tables.
package kg_io_pkg;

    typedef enum logic [2:0] {
        SEC_RHO = 3'd0,
        SEC_K   = 3'd1,
        SEC_S1  = 3'd2,
        SEC_S2  = 3'd3,
        SEC_T1  = 3'd4,
        SEC_T0  = 3'd5,
        SEC_TR  = 3'd6
    } sec_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_UNLOAD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int DEF_W          = 64;
    localparam int DEF_SEED_WORDS = 4;
    localparam int DEF_S1_WORDS   = 48;
    localparam int DEF_S2_WORDS   = 48;
    localparam int DEF_T1_WORDS   = 160;
    localparam int DEF_T0_WORDS   = 208;

    // Index of the final entry in each order table.
    localparam logic [2:0] HP_LAST_IDX = 3'd6;
    localparam logic [2:0] LR_LAST_IDX = 3'd7;

    // Section emitted at position idx of the unload sequence.
    // High-performance: RHO,K,S1,S2,T1,T0,TR.
    // Low-resource:     RHO,K,TR,S1,S2,T0,RHO,T1 (rho is resent ahead of t1).
    function automatic sec_e order_sec(input logic hp, input logic [2:0] idx);
        sec_e s;
        s = SEC_RHO;
        if (hp) begin
            case (idx)
                3'd0:    s = SEC_RHO;
                3'd1:    s = SEC_K;
                3'd2:    s = SEC_S1;
                3'd3:    s = SEC_S2;
                3'd4:    s = SEC_T1;
                3'd5:    s = SEC_T0;
                3'd6:    s = SEC_TR;
                default: s = SEC_RHO;
            endcase
        end else begin
            case (idx)
                3'd0:    s = SEC_RHO;
                3'd1:    s = SEC_K;
                3'd2:    s = SEC_TR;
                3'd3:    s = SEC_S1;
                3'd4:    s = SEC_S2;
                3'd5:    s = SEC_T0;
                3'd6:    s = SEC_RHO;
                3'd7:    s = SEC_T1;
                default: s = SEC_RHO;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/kg_stream_fifo2.sv
// kg_stream_fifo2: two-entry W-wide output FIFO with occupancy count.
// Head word is presented combinationally on data_o; push while full is
// dropped unless a pop frees the slot in the same cycle.
module kg_stream_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Storage, pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/kg_stream_io.sv
// kg_stream_io: DUT-side endpoint of the keygen word stream.
// Loads the seed from the host, waits for the core, then streams the key
// sections out of the result memories through a 2-entry FIFO.
// Optional build macro KG_STREAM_IO_PERF_CNT_EN adds load/exec/unload
// cycle counters as extra 32-bit outputs.
module kg_stream_io
    import kg_io_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int HIGH_PERF  = 1,
    parameter int SEED_WORDS = DEF_SEED_WORDS,
    parameter int S1_WORDS   = DEF_S1_WORDS,
    parameter int S2_WORDS   = DEF_S2_WORDS,
    parameter int T1_WORDS   = DEF_T1_WORDS,
    parameter int T0_WORDS   = DEF_T0_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  valid_i,
    output logic                  ready_i,
    input  logic [W-1:0]          data_i,
    output logic [SEED_WORDS*W-1:0] seed_o,
    output logic                  seed_valid,
    input  logic                  core_done,
    output logic                  rd_en,
    output logic [2:0]            rd_sec,
    output logic [7:0]            rd_addr,
    input  logic [W-1:0]          rd_data,
    output logic                  valid_o,
    input  logic                  ready_o,
    output logic [W-1:0]          data_o,
    output logic                  done
`ifdef KG_STREAM_IO_PERF_CNT_EN
    ,
    output logic [31:0]           load_cycles,
    output logic [31:0]           exec_cycles,
    output logic [31:0]           unload_cycles
`endif
);

    localparam int         CW       = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;
    localparam logic [2:0] LAST_IDX = (HIGH_PERF != 0) ? HP_LAST_IDX : LR_LAST_IDX;

    state_t                  state_q;
    logic [CW-1:0]           ctr_q;
    logic [SEED_WORDS*W-1:0] seed_q;
    logic                    seed_valid_q;
    logic                    done_q;
    logic [2:0]              sec_idx_q;
    logic [7:0]              addr_q;
    logic                    all_issued_q;
    logic                    inflight_q;

    sec_e       cur_sec;
    logic [1:0] fifo_cnt;
    logic [1:0] occ_nxt;
    logic       pop;
    logic       issue;
    logic       last_word;
    logic       last_sec;
    logic       drain;

    // Final address of a section; counts come straight from the parameters.
    function automatic logic [7:0] last_addr(input sec_e s);
        logic [7:0] a;
        case (s)
            SEC_S1:  a = 8'(S1_WORDS - 1);
            SEC_S2:  a = 8'(S2_WORDS - 1);
            SEC_T1:  a = 8'(T1_WORDS - 1);
            SEC_T0:  a = 8'(T0_WORDS - 1);
            default: a = 8'(SEED_WORDS - 1);
        endcase
        return a;
    endfunction

    assign cur_sec   = order_sec(HIGH_PERF != 0, sec_idx_q);
    assign last_word = (addr_q == last_addr(cur_sec));
    assign last_sec  = (sec_idx_q == LAST_IDX);

    assign valid_o = (fifo_cnt != 2'd0);
    assign pop     = valid_o && ready_o;
    // Occupancy after this cycle's pop: counting the pop lets a new read go
    // out every cycle while the host drains, giving 1 word/cycle.
    assign occ_nxt = fifo_cnt - {1'b0, pop};
    assign issue   = (state_q == S_UNLOAD) && !all_issued_q &&
                     (({1'b0, occ_nxt} + {2'b0, inflight_q}) < 3'd2);
    assign drain   = (state_q == S_UNLOAD) && all_issued_q && !inflight_q &&
                     (occ_nxt == 2'd0);

    assign ready_i    = (state_q == S_LOAD);
    assign seed_o     = seed_q;
    assign seed_valid = seed_valid_q;
    assign done       = done_q;
    assign rd_en      = issue;
    assign rd_sec     = cur_sec;
    assign rd_addr    = addr_q;

    kg_stream_fifo2 #(.W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .data_i  (rd_data),
        .pop_i   (pop),
        .data_o  (data_o),
        .count_o (fifo_cnt)
    );

    // Control FSM: seed load, wait for core, section walk, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ctr_q        <= '0;
            seed_q       <= '0;
            seed_valid_q <= 1'b0;
            done_q       <= 1'b0;
            sec_idx_q    <= 3'd0;
            addr_q       <= 8'd0;
            all_issued_q <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            seed_valid_q <= 1'b0;
            done_q       <= 1'b0;
            inflight_q   <= issue;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        ctr_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (valid_i) begin
                        seed_q[(SEED_WORDS - 1 - int'(ctr_q)) * W +: W] <= data_i;
                        ctr_q <= ctr_q + CW'(1);
                        if (ctr_q == CW'(SEED_WORDS - 1)) begin
                            seed_valid_q <= 1'b1;
                            state_q      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_q      <= S_UNLOAD;
                        sec_idx_q    <= 3'd0;
                        addr_q       <= 8'd0;
                        all_issued_q <= 1'b0;
                    end
                end
                S_UNLOAD: begin
                    if (issue) begin
                        if (last_word) begin
                            addr_q <= 8'd0;
                            if (last_sec) begin
                                all_issued_q <= 1'b1;
                                sec_idx_q    <= 3'd0;
                            end else begin
                                sec_idx_q <= sec_idx_q + 3'd1;
                            end
                        end else begin
                            addr_q <= addr_q + 8'd1;
                        end
                    end
                    if (drain) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef KG_STREAM_IO_PERF_CNT_EN
    logic [31:0] load_run_q;
    logic [31:0] exec_run_q;
    logic [31:0] unload_run_q;

    // Per-phase cycle counters; snapshot into the outputs as done fires.
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && start)) begin
            load_run_q    <= '0;
            exec_run_q    <= '0;
            unload_run_q  <= '0;
            load_cycles   <= '0;
            exec_cycles   <= '0;
            unload_cycles <= '0;
        end else begin
            if (state_q == S_LOAD)   load_run_q   <= load_run_q + 32'd1;
            if (state_q == S_WAIT)   exec_run_q   <= exec_run_q + 32'd1;
            if (state_q == S_UNLOAD) unload_run_q <= unload_run_q + 32'd1;
            if (drain) begin
                load_cycles   <= load_run_q;
                exec_cycles   <= exec_run_q;
                unload_cycles <= unload_run_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kg_stream_io.sv
// tb_kg_stream_io: directed/randomized bench for kg_stream_io.
// Two instances: dut0 with HIGH_PERF=1, dut1 with HIGH_PERF=0.
`timescale 1ns/1ps
module tb_kg_stream_io;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           start, valid_i, core_done, ready_o;
    logic [1:0][W-1:0]    data_i;
    logic [1:0]           ready_i, seed_valid, rd_en, valid_o, done;
    logic [1:0][2:0]      rd_sec;
    logic [1:0][7:0]      rd_addr;
    logic [1:0][W-1:0]    rd_data = '0;
    logic [1:0][W-1:0]    data_o;
    logic [1:0][4*W-1:0]  seed_o;
`ifdef KG_STREAM_IO_PERF_CNT_EN
    logic [1:0][31:0]     load_cycles, exec_cycles, unload_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ts, tl, tc, td;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    kg_stream_io #(.HIGH_PERF(1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .valid_i(valid_i[0]), .ready_i(ready_i[0]),
        .data_i(data_i[0]), .seed_o(seed_o[0]), .seed_valid(seed_valid[0]),
        .core_done(core_done[0]), .rd_en(rd_en[0]), .rd_sec(rd_sec[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .valid_o(valid_o[0]), .ready_o(ready_o[0]), .data_o(data_o[0]),
        .done(done[0])
`ifdef KG_STREAM_IO_PERF_CNT_EN
        , .load_cycles(load_cycles[0]), .exec_cycles(exec_cycles[0]),
        .unload_cycles(unload_cycles[0])
`endif
    );

    kg_stream_io #(.HIGH_PERF(0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .valid_i(valid_i[1]), .ready_i(ready_i[1]),
        .data_i(data_i[1]), .seed_o(seed_o[1]), .seed_valid(seed_valid[1]),
        .core_done(core_done[1]), .rd_en(rd_en[1]), .rd_sec(rd_sec[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .valid_o(valid_o[1]), .ready_o(ready_o[1]), .data_o(data_o[1]),
        .done(done[1])
`ifdef KG_STREAM_IO_PERF_CNT_EN
        , .load_cycles(load_cycles[1]), .exec_cycles(exec_cycles[1]),
        .unload_cycles(unload_cycles[1])
`endif
    );

    // Result-memory content: every word is tagged with its section and address.
    function automatic logic [W-1:0] mem_word(input int sec, input int addr);
        return 64'hC0DE_0000_0000_0000 | (64'(sec) << 32) | 64'(addr);
    endfunction

    // Synchronous-read result memory, one cycle of latency.
    always @(posedge clk) begin
        if (rd_en[0]) rd_data[0] <= mem_word(int'(rd_sec[0]), int'(rd_addr[0]));
        if (rd_en[1]) rd_data[1] <= mem_word(int'(rd_sec[1]), int'(rd_addr[1]));
    end

    // Section codes: RHO=0 K=1 S1=2 S2=3 T1=4 T0=5 TR=6.
    function automatic int sec_len(input int s);
        case (s)
            2: return 48;
            3: return 48;
            4: return 160;
            5: return 208;
            default: return 4;
        endcase
    endfunction

    task automatic build_expected(input int k);
        int hp_order[7] = '{0, 1, 2, 3, 4, 5, 6};
        int lr_order[8] = '{0, 1, 6, 2, 3, 5, 0, 4};
        exp_q.delete();
        if (k == 0) begin
            foreach (hp_order[i])
                for (int a = 0; a < sec_len(hp_order[i]); a++) exp_q.push_back(mem_word(hp_order[i], a));
        end else begin
            foreach (lr_order[i])
                for (int a = 0; a < sec_len(lr_order[i]); a++) exp_q.push_back(mem_word(lr_order[i], a));
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pulse start, then feed four seed words with `gap` idle cycles before each.
    task automatic load_seed(input int k, input int gap, input bit fixed);
        logic [3:0][W-1:0] w;
        int idx, rdy, sv, g;
        bit acc;
        for (int i = 0; i < 4; i++) w[i] = fixed ? W'(i + 1) : {$urandom, $urandom};
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        ts = cyc;
        idx = 0; rdy = 0; sv = 0; g = gap;
        for (int c = 0; c < 200 && idx < 4; c++) begin
            if (g > 0) begin
                valid_i[k] = 1'b0;
                g--;
            end else begin
                valid_i[k] = 1'b1;
                data_i[k]  = w[idx];
            end
            if (ready_i[k]) rdy++;
            if (seed_valid[k]) sv++;
            acc = valid_i[k] && ready_i[k];
            tick();
            if (acc) begin
                idx++;
                g = gap;
            end
        end
        valid_i[k] = 1'b0;
        tl = cyc;
        check("seed_words_accepted", idx, 4);
        check("seed_valid_pulse", seed_valid[k], 1'b1);
        check("ready_i_drop", ready_i[k], 1'b0);
        check("seed_value", seed_o[k], {w[0], w[1], w[2], w[3]});
        check("seed_valid_early", sv, 0);
        if (gap == 0) check("ready_i_cycles", rdy, 4);
        tick();
        check("seed_valid_once", seed_valid[k], 1'b0);
    endtask

    // Wait, poke a busy start, fire core_done and drain the stream.
    // abort_at>0 resets the block once that many words have been accepted.
    task automatic unload(input int k, input int duty, input int abort_at, input int wait_cyc);
        int n, dcnt, first, nw;
        bit stall, got_done;
        logic [W-1:0] held;
        logic [1:0] occ;
        build_expected(k);
        nw = exp_q.size();
        repeat (wait_cyc) tick();
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        core_done[k] = 1'b1;
        ready_o[k] = 1'b0;
        tick();
        core_done[k] = 1'b0;
        tc = cyc;
        check("first_valid_not_early", valid_o[k], 1'b0);
        n = 0; dcnt = 0; first = -1; stall = 0; held = '0; got_done = 0;
        for (int c = 0; c < 20000; c++) begin
            ready_o[k] = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            if (stall) begin
                check("stall_valid_held", valid_o[k], 1'b1);
                check("stall_data_held", data_o[k], held);
            end
            occ = (k == 0) ? dut0.fifo_cnt : dut1.fifo_cnt;
            check("fifo_occ_le2", (occ <= 2'd2), 1'b1);
            if (done[k]) begin
                dcnt++;
                td = cyc;
                got_done = 1;
                break;
            end
            if (valid_o[k] && first < 0) first = cyc;
            if (valid_o[k] && ready_o[k]) begin
                check("word_in_range", (n < nw), 1'b1);
                if (n < nw) check($sformatf("word_%0d", n), data_o[k], exp_q[n]);
                n++;
            end
            stall = valid_o[k] && !ready_o[k];
            held  = data_o[k];
            if (abort_at > 0 && n == abort_at) break;
            tick();
        end
        ready_o[k] = 1'b0;
        check("first_valid_latency", first, tc + 2);
        if (abort_at > 0) begin
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("abort_valid_o", valid_o[k], 1'b0);
            check("abort_ready_i", ready_i[k], 1'b0);
            check("abort_rd_en", rd_en[k], 1'b0);
            check("abort_seed_cleared", seed_o[k], '0);
            for (int c = 0; c < 600; c++) begin
                tick();
                if (done[k]) dcnt++;
            end
            check("abort_no_done", dcnt, 0);
            return;
        end
        check("done_seen", got_done, 1'b1);
        check("word_count", n, nw);
        if (duty >= 100) check("throughput_done_cycle", td, tc + 2 + nw);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done[k]) dcnt++;
        end
        check("done_once", dcnt, 1);
        check("idle_valid_o", valid_o[k], 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = '0; valid_i = '0; core_done = '0; ready_o = '0; data_i = '0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_ready_i", ready_i[k], 1'b0);
            check("rst_valid_o", valid_o[k], 1'b0);
            check("rst_done", done[k], 1'b0);
            check("rst_seed_valid", seed_valid[k], 1'b0);
            check("rst_rd_en", rd_en[k], 1'b0);
            check("rst_seed_o", seed_o[k], '0);
            check("rst_data_o", data_o[k], '0);
        end
        rst = 1'b0;
        tick();

        // core_done outside S_WAIT has no effect.
        core_done[0] = 1'b1;
        tick();
        core_done[0] = 1'b0;
        tick();
        check("idle_core_done_ignored", valid_o[0], 1'b0);

        // Fixed seed 1..4, then full high-perf unload at full rate.
        load_seed(0, 0, 1'b1);
        unload(0, 100, 0, 3);

        // Low-resource order at full rate.
        load_seed(1, 0, 1'b0);
        unload(1, 100, 0, 0);

        // Random backpressure, both orders.
        load_seed(0, 0, 1'b0);
        unload(0, 30, 0, 0);
        load_seed(1, 1, 1'b0);
        unload(1, 30, 0, 2);

        // Abort at word 100, then a clean full operation.
        load_seed(0, 0, 1'b0);
        unload(0, 100, 100, 0);
        load_seed(0, 0, 1'b0);
        unload(0, 100, 0, 0);

`ifdef KG_STREAM_IO_PERF_CNT_EN
        load_seed(0, 2, 1'b0);
        unload(0, 100, 0, 50);
        check("perf_load_cycles", load_cycles[0], 32'(tl - ts));
        check("perf_exec_cycles", exec_cycles[0], 32'(tc - tl));
        check("perf_unload_cycles", unload_cycles[0], 32'(td - tc));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
